// File: rtl/reg_dump_scanner_pkg.sv
// ============================================================================
//  Module   : reg_dump_scanner_pkg
//  Purpose  : Shared debug-path definitions: dump FSM state encoding and the
//             default register-file geometry used by the dump scanner.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_dump_scanner_pkg;

   // Register-file geometry defaults
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_DATA_W   = 32;

   // Dump scanner FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } dump_state_e;

endpackage : reg_dump_scanner_pkg

`default_nettype wire

// File: rtl/reg_dump_scanner.sv
// ============================================================================
//  Module   : reg_dump_scanner
//  Purpose  : Walks register addresses 0..NUM_REGS-1 through the register
//             file debug port, captures each word and streams it out as an
//             (address, data) beat on a valid/ready interface while keeping a
//             running XOR checksum of every word sent.
//  Ports    : clk          - clock, all state updates on posedge
//             rst          - asynchronous active-high reset
//             start_i      - begin a dump (sampled only in IDLE)
//             abort_i      - cancel a dump in READ/SEND
//             debug_addr_o - address driven to the register file debug port
//             debug_data_i - combinational read data from the debug port
//             out_valid_o  - beat valid
//             out_ready_i  - consumer accepts beat
//             out_addr_o   - register address of current beat
//             out_data_o   - captured register value of current beat
//             busy_o       - high in READ or SEND
//             done_o       - one-cycle pulse after the last beat is accepted
//             checksum_o   - XOR of all words sent in the current/last dump
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_scanner
   import reg_dump_scanner_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] debug_addr_o,
   input  logic [DATA_W-1:0] debug_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] checksum_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   dump_state_e       state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic              out_valid_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_data_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] checksum_q;
   logic [DATA_W-1:0] checksum_d;

   // The increment is only used after the terminal compare fails, so the
   // counter can never wrap past LAST_ADDR.
   assign addr_d     = addr_q + ADDR_W'(1);
   assign checksum_d = checksum_q ^ debug_data_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         checksum_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  addr_q     <= '0;
                  checksum_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_READ;
               end
            end

            ST_READ: begin
               if (abort_i) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  out_data_q  <= debug_data_i;
                  out_addr_q  <= addr_q;
                  out_valid_q <= 1'b1;
                  checksum_q  <= checksum_d;
                  state_q     <= ST_SEND;
               end
            end

            ST_SEND: begin
               // Abort wins over a handshake in the same cycle.
               if (abort_i) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  if (addr_q == LAST_ADDR) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     addr_q  <= addr_d;
                     state_q <= ST_READ;
                  end
               end
            end

            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign debug_addr_o = addr_q;
   assign out_valid_o  = out_valid_q;
   assign out_addr_o   = out_addr_q;
   assign out_data_o   = out_data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign checksum_o   = checksum_q;

endmodule : reg_dump_scanner

`default_nettype wire

// File: tb/tb_reg_dump_scanner.sv
// ============================================================================
//  Module   : tb_reg_dump_scanner
//  Purpose  : Self-checking bench for reg_dump_scanner with a register-file
//             model on the debug port and a beat scoreboard.
//  Ports    : none (testbench top)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        abort_i;
   logic [4:0]  debug_addr_o;
   logic [31:0] debug_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [4:0]  out_addr_o;
   logic [31:0] out_data_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] checksum_o;

   logic [31:0] regs [32];

   assign debug_data_i = regs[debug_addr_o];

   always #5 clk = ~clk;

   reg_dump_scanner dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .debug_addr_o (debug_addr_o),
      .debug_data_i (debug_data_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_addr_o   (out_addr_o),
      .out_data_o   (out_data_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .checksum_o   (checksum_o)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } beat_t;

   // One dump scenario: ready pattern, optional stall/write, expectations.
   typedef struct {
      int          mode;        // 0 ready high, 1 random, 2 every third cycle
      int          stall_addr;  // -1 none, else stall this beat for 4 cycles
      bit          writes;      // apply r20/r3 writes during the stall
      int          exp_done;    // expected done cycle after start edge, -1 skip
      logic [31:0] exp_ck;
   } vec_t;

   beat_t exp_q [$];
   vec_t  tbl [4];
   int    checks   = 0;
   int    failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic restore_regs();
      regs[0] = 32'h0;
      for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;
   endtask

   task automatic run_dump(input int mode, input int stall_addr, input bit writes,
                           input int exp_done, input logic [31:0] exp_ck);
      beat_t       b;
      int          cyc;
      int          done_cyc;
      int          stall_cnt;
      bit          r;
      bit          hs;
      bit          prev_stall;
      logic [4:0]  pa;
      logic [31:0] pd;

      exp_q.delete();
      for (int a = 0; a < 32; a++) begin
         b.addr = a[4:0];
         b.data = (writes && a == 20) ? 32'hDEAD_BEEF : regs[a];
         exp_q.push_back(b);
      end

      start_i     = 1'b1;
      out_ready_i = 1'b0;
      step();
      start_i = 1'b0;
      chk("start_busy", 32'(busy_o), 32'd1);
      chk("start_ck_clear", checksum_o, 32'h0);

      cyc        = 0;
      done_cyc   = -1;
      stall_cnt  = 0;
      prev_stall = 1'b0;
      pa         = '0;
      pd         = '0;
      while (cyc < 1000 && done_cyc < 0) begin
         case (mode)
            1:       r = 1'($urandom_range(0, 1));
            2:       r = (cyc % 3 == 0);
            default: r = 1'b1;
         endcase
         if (stall_addr >= 0 && out_valid_o && 32'(out_addr_o) == stall_addr && stall_cnt < 4) begin
            r = 1'b0;
            stall_cnt++;
            if (stall_cnt == 2 && writes) begin
               regs[20] = 32'hDEAD_BEEF;
               regs[3]  = 32'hCAFE_0000;
            end
         end
         start_i     = (mode == 1 && cyc == 9);
         out_ready_i = r;
         if (prev_stall) begin
            chk("stall_addr_stable", 32'(out_addr_o), 32'(pa));
            chk("stall_data_stable", out_data_o, pd);
         end
         hs         = out_valid_o && r;
         prev_stall = out_valid_o && !r;
         pa         = out_addr_o;
         pd         = out_data_o;
         step();
         cyc++;
         if (hs) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 32'd1, 32'd0);
            end else begin
               b = exp_q.pop_front();
               chk("beat_addr", 32'(pa), 32'(b.addr));
               chk("beat_data", pd, b.data);
            end
         end
         if (done_o) done_cyc = cyc;
      end
      start_i     = 1'b0;
      out_ready_i = 1'b0;

      chk("done_seen", 32'(done_cyc >= 0), 32'd1);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
      chk("beats_left", 32'(exp_q.size()), 32'd0);
      chk("checksum", checksum_o, exp_ck);
      step();
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("idle_not_busy", 32'(busy_o), 32'd0);
      chk("checksum_hold", checksum_o, exp_ck);
   endtask

   initial begin
      int n;

      // XOR of 0x10000001..0x1000001F is 0x10000000; replacing r20 with
      // 0xDEADBEEF gives 0x10000000 ^ 0x10000014 ^ 0xDEADBEEF = 0xDEADBEFB.
      tbl[0] = '{mode: 0, stall_addr: -1, writes: 1'b0, exp_done: 64, exp_ck: 32'h1000_0000};
      tbl[1] = '{mode: 1, stall_addr: -1, writes: 1'b0, exp_done: -1, exp_ck: 32'h1000_0000};
      tbl[2] = '{mode: 2, stall_addr: -1, writes: 1'b0, exp_done: -1, exp_ck: 32'h1000_0000};
      tbl[3] = '{mode: 0, stall_addr: 5,  writes: 1'b1, exp_done: -1, exp_ck: 32'hDEAD_BEFB};

      restore_regs();
      rst         = 1'b1;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      out_ready_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_debug_addr", 32'(debug_addr_o), 32'd0);
      chk("rst_out_addr", 32'(out_addr_o), 32'd0);
      chk("rst_out_data", out_data_o, 32'h0);
      chk("rst_checksum", checksum_o, 32'h0);

      for (int t = 0; t < 4; t++) begin
         run_dump(tbl[t].mode, tbl[t].stall_addr, tbl[t].writes, tbl[t].exp_done, tbl[t].exp_ck);
         restore_regs();
      end

      // Abort in SEND of addr 10 with a simultaneous handshake.
      start_i     = 1'b1;
      out_ready_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while (!(out_valid_o && out_addr_o == 5'd10) && n < 200) begin
         step();
         n++;
      end
      chk("abort_reach_addr10", 32'(out_valid_o && out_addr_o == 5'd10), 32'd1);
      abort_i     = 1'b1;
      out_ready_i = 1'b1;
      step();
      abort_i     = 1'b0;
      out_ready_i = 1'b0;
      chk("abort_valid_low", 32'(out_valid_o), 32'd0);
      chk("abort_not_busy", 32'(busy_o), 32'd0);
      chk("abort_addr_held", 32'(debug_addr_o), 32'd10);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (done_o || busy_o) n++;
         step();
      end
      chk("abort_no_done", n, 0);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;

      // Restart after abort begins at addr 0 with a cleared checksum.
      run_dump(0, -1, 1'b0, 64, 32'h1000_0000);

      // Asynchronous reset in SEND of addr 7.
      start_i     = 1'b1;
      out_ready_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while (!(out_valid_o && out_addr_o == 5'd7) && n < 200) begin
         step();
         n++;
      end
      out_ready_i = 1'b0;
      chk("rst_reach_addr7", 32'(out_valid_o && out_addr_o == 5'd7), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_done", 32'(done_o), 32'd0);
      chk("arst_debug_addr", 32'(debug_addr_o), 32'd0);
      chk("arst_out_addr", 32'(out_addr_o), 32'd0);
      chk("arst_out_data", out_data_o, 32'h0);
      chk("arst_checksum", checksum_o, 32'h0);
      #1 rst = 1'b0;
      step();
      step();
      chk("post_rst_no_done", 32'(done_o), 32'd0);
      chk("post_rst_idle", 32'(busy_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_reg_dump_scanner

`default_nettype wire
